// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle CPU control FSM sequencing fetch/decode/exec/mem/writeback
module multi_cycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o,
    output logic [1:0] alu_ctl_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;
    state_t state_q, state_d;
    logic rdy, r_ok;
    logic [1:0] r_alu;
    assign rdy   = MEM_WAIT_EN ? mem_ready_i : 1'b1;
    assign r_ok  = funct_i inside {6'h20, 6'h22, 6'h24, 6'h27};
    assign r_alu = funct_i == 6'h22 ? 2'b01 : funct_i == 6'h24 ? 2'b10 :
                   funct_i == 6'h27 ? 2'b11 : 2'b00;
    assign state_o = state_q;
    always_ff @(posedge clk)
        state_q <= rst_n ? state_d : FETCH;
    // Held reset gates every output to 0, so an aborted instruction writes nothing.
    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_source_o  = 2'b00;
        alu_ctl_o    = 2'b00;
        instr_done_o = 1'b0;
        illegal_op_o = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = rdy;
                    pc_write_o  = rdy;
                    state_d     = rdy ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b_o = 2'b11;
                    case (opcode_i)
                        6'h00:        state_d = EXEC;
                        6'h23, 6'h2B: state_d = MEM_ADDR;
                        6'h04:        state_d = BRANCH;
                        6'h02:        state_d = JUMP;
                        6'h08:        state_d = ADDI_EX;
                        default: begin
                            illegal_op_o = 1'b1;
                            state_d      = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_d     = opcode_i == 6'h2B ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                    state_d    = rdy ? MEM_WB : MEM_RD;
                end
                MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = FETCH;
                end
                MEM_WR: begin
                    mem_write_o  = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = rdy;
                    state_d      = rdy ? FETCH : MEM_WR;
                end
                EXEC: begin
                    alu_src_a_o  = 1'b1;
                    alu_ctl_o    = r_alu;
                    illegal_op_o = !r_ok;
                    state_d      = r_ok ? R_WB : FETCH;
                end
                R_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 1'b1;
                    alu_ctl_o    = r_alu;
                    instr_done_o = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    alu_src_a_o  = 1'b1;
                    alu_ctl_o    = 2'b01;
                    pc_source_o  = 2'b01;
                    pc_write_o   = zero_i;
                    instr_done_o = 1'b1;
                    state_d      = FETCH;
                end
                JUMP: begin
                    pc_source_o  = 2'b10;
                    pc_write_o   = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = FETCH;
                end
                ADDI_EX: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_d     = ADDI_WB;
                end
                ADDI_WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end
endmodule
